// File: rtl/frb_template_player_if.sv
// Bus bundle for frb_template_player: host template writes, playback control,
// sample stream in/out and both template RAM ports.
// The player takes the slave modport; the host/RAM side takes master.
interface frb_template_player_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    // host write port
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    // playback control
    logic                  trigger;
    logic                  stop;
    logic [ADDR_WIDTH:0]   len;
    // sample stream
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  inject;
    logic                  busy;
    logic                  done;
    logic                  wr_err;
    // template RAM ports
    logic                  ram_we_a;
    logic [ADDR_WIDTH-1:0] ram_addr_a;
    logic [DATA_WIDTH-1:0] ram_dat_a;
    logic                  ram_we_b;
    logic [ADDR_WIDTH-1:0] ram_addr_b;
    logic [DATA_WIDTH-1:0] ram_dout_b;

    modport slave (
        input  wr_en, wr_addr, wr_data, trigger, stop, len, din, ram_dout_b,
        output ram_we_a, ram_addr_a, ram_dat_a, ram_we_b, ram_addr_b,
               dout, inject, busy, done, wr_err
    );

    modport master (
        output wr_en, wr_addr, wr_data, trigger, stop, len, din, ram_dout_b,
        input  ram_we_a, ram_addr_a, ram_dat_a, ram_we_b, ram_addr_b,
               dout, inject, busy, done, wr_err
    );
endinterface

// File: rtl/frb_template_player.sv
// Synthetic-FRB template playback controller.
// Host writes reach RAM port A only while idle. On a trigger the template is
// read through port B and saturating-added onto the sample stream, which is
// always delayed by two cycles so injected and plain samples stay aligned.
// Optional build macro PLAY_LOOP_EN: playback wraps at the end of the template
// and runs until stop or rst, with done pulsing once per pass.
module frb_template_player #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    frb_template_player_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                        state_q, state_d;
    logic [ADDR_WIDTH:0]           len_q, len_d;
    logic [ADDR_WIDTH-1:0]         addr_b_q, addr_b_d;
    // rd_vld: a read was issued last cycle, so ram_dout_b holds a template sample
    logic                          rd_vld_q, rd_vld_d;
    // last: that read was the final address of a pass
    logic                          last_q, last_d;
    logic signed [DATA_WIDTH-1:0]  din_dly_q, din_dly_d;
    logic signed [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                          inject_q, inject_d;
    logic                          done_q, done_d;
    logic                          busy_q, busy_d;
    logic                          wr_err_q, wr_err_d;

    logic                          at_last;
    logic signed [DATA_WIDTH:0]    tmpl_ext;
    logic signed [DATA_WIDTH:0]    sum;

    assign at_last = ({1'b0, addr_b_q} == (len_q - 1'b1));

    // Next-state and read-address sequencing for the playback FSM
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_b_d = addr_b_q;
        rd_vld_d = 1'b0;
        last_d   = 1'b0;
        case (state_q)
            IDLE: begin
                addr_b_d = '0;
                if (bus.trigger && (bus.len != '0)) begin
                    state_d = PLAY;
                    len_d   = bus.len;
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    // the read presented this cycle is discarded; earlier ones drain
                    state_d  = IDLE;
                    addr_b_d = '0;
                end else begin
                    rd_vld_d = 1'b1;
                    last_d   = at_last;
                    if (at_last) begin
                        addr_b_d = '0;
`ifdef PLAY_LOOP_EN
                        state_d  = PLAY;
`else
                        state_d  = IDLE;
`endif
                    end else begin
                        addr_b_d = addr_b_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d == PLAY);
        wr_err_d = bus.wr_en && (state_q == PLAY);
    end

    // Stream datapath: one delay stage for din, then saturating add into dout
    always_comb begin
        din_dly_d = bus.din;
        tmpl_ext  = rd_vld_q ? {bus.ram_dout_b[DATA_WIDTH-1], bus.ram_dout_b} : '0;
        sum       = {din_dly_q[DATA_WIDTH-1], din_dly_q} + tmpl_ext;
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
            dout_d = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        else
            dout_d = sum[DATA_WIDTH-1:0];
        inject_d = rd_vld_q;
        done_d   = last_q;
    end

    // All state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            addr_b_q  <= '0;
            rd_vld_q  <= 1'b0;
            last_q    <= 1'b0;
            din_dly_q <= '0;
            dout_q    <= '0;
            inject_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_b_q  <= addr_b_d;
            rd_vld_q  <= rd_vld_d;
            last_q    <= last_d;
            din_dly_q <= din_dly_d;
            dout_q    <= dout_d;
            inject_q  <= inject_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // Port A is a straight pass-through, gated so the template is frozen during playback
    assign bus.ram_we_a   = bus.wr_en && (state_q == IDLE) && !rst;
    assign bus.ram_addr_a = bus.wr_addr;
    assign bus.ram_dat_a  = bus.wr_data;
    assign bus.ram_we_b   = 1'b0;
    assign bus.ram_addr_b = addr_b_q;
    assign bus.dout       = dout_q;
    assign bus.inject     = inject_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wr_err     = wr_err_q;

endmodule
